// File: rtl/matrix_pkg.sv
// Shared constants and FSM state encoding for the matrix text formatter.
package matrix_pkg;

   localparam int MAX_DIM = 5;

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LATCH  = 3'd2,
      S_EMIT   = 3'd3,
      S_TXWAIT = 3'd4,
      S_NEXT   = 3'd5,
      S_FIN    = 3'd6
   } state_t;

endpackage

// File: rtl/u8_to_dec.sv
// Combinational 8-bit unsigned to three BCD digits plus significant-digit count.
module u8_to_dec (
   input  logic [7:0] value,
   output logic [3:0] hund,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [1:0] ndig
);

   logic [7:0] rem;
   logic [7:0] tens_val;

   // Hundreds by compare/subtract, tens by a descending table search, ones as remainder.
   always_comb begin
      hund     = 4'd0;
      tens     = 4'd0;
      tens_val = 8'd0;
      rem      = value;
      if (value >= 8'd200) begin
         hund = 4'd2;
         rem  = value - 8'd200;
      end else if (value >= 8'd100) begin
         hund = 4'd1;
         rem  = value - 8'd100;
      end
      for (int k = 9; k >= 1; k--) begin
         if (tens == 4'd0 && rem >= 8'(k * 10)) begin
            tens     = 4'(k);
            tens_val = 8'(k * 10);
         end
      end
      ones = 4'(rem - tens_val);
      if (hund != 4'd0)
         ndig = 2'd3;
      else if (tens != 4'd0)
         ndig = 2'd2;
      else
         ndig = 2'd1;
   end

endmodule

// File: rtl/matrix_tx_formatter.sv
// Streams an m x n byte matrix as decimal ASCII text (SEP between columns, CR LF per row)
// to a byte-wide UART transmitter, one byte per tx_start/tx_busy handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; bad dimensions pulse err
// S_FETCH  | rd_en for the current element address
// S_LATCH  | rd_data valid; load digit/trailer bytes into the queue
// S_EMIT   | launch the queue head once the UART is free
// S_TXWAIT | tx_start cycle ignored, then wait for tx_busy to drop
// S_NEXT   | advance column/row, or finish after the last element
// S_FIN    | pulse done, busy drops
module matrix_tx_formatter
   import matrix_pkg::*;
#(
   parameter int         MAX_DIM = matrix_pkg::MAX_DIM,
   parameter int         ADDR_W  = 5,
   parameter logic [7:0] SEP     = 8'h20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        dim_m,
   input  logic [2:0]        dim_n,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state, state_nxt;
   logic [2:0]        m_r, n_r, row, col;
   logic [ADDR_W-1:0] addr;
   logic [4:0][7:0]   q, q_nxt;
   logic [2:0]        q_len, q_len_nxt, q_idx;
   logic [3:0]        hund, tens, ones;
   logic [1:0]        ndig;
   logic              dims_ok, last_col, last_elem, bytes_left;

   u8_to_dec u_dec (
      .value (rd_data),
      .hund  (hund),
      .tens  (tens),
      .ones  (ones),
      .ndig  (ndig)
   );

   assign dims_ok    = (dim_m != 3'd0) && (dim_n != 3'd0) &&
                       (dim_m <= 3'(MAX_DIM)) && (dim_n <= 3'(MAX_DIM));
   assign last_col   = (col == n_r - 3'd1);
   assign last_elem  = last_col && (row == m_r - 3'd1);
   assign bytes_left = (q_idx < q_len);

   assign rd_en   = (state == S_FETCH);
   assign rd_addr = addr;
   assign busy    = (state != S_IDLE) && (state != S_FIN);
   assign done    = (state == S_FIN);

   // Byte queue for the element on rd_data: significant digits, then SEP or CR LF.
   always_comb begin
      q_nxt     = '0;
      q_len_nxt = {1'b0, ndig};
      case (ndig)
         2'd3: begin
            q_nxt[0] = ASCII_0 + {4'h0, hund};
            q_nxt[1] = ASCII_0 + {4'h0, tens};
            q_nxt[2] = ASCII_0 + {4'h0, ones};
         end
         2'd2: begin
            q_nxt[0] = ASCII_0 + {4'h0, tens};
            q_nxt[1] = ASCII_0 + {4'h0, ones};
         end
         default: q_nxt[0] = ASCII_0 + {4'h0, ones};
      endcase
      if (last_col) begin
         q_nxt[q_len_nxt]        = ASCII_CR;
         q_nxt[q_len_nxt + 3'd1] = ASCII_LF;
         q_len_nxt               = q_len_nxt + 3'd2;
      end else begin
         q_nxt[q_len_nxt] = SEP;
         q_len_nxt        = q_len_nxt + 3'd1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; tx_start high marks the UART-latency cycle that TXWAIT skips.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start && dims_ok) state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_LATCH;
         S_LATCH:  state_nxt = S_EMIT;
         S_EMIT:   if (!tx_busy) state_nxt = S_TXWAIT;
         S_TXWAIT: if (!tx_start && !tx_busy) state_nxt = bytes_left ? S_EMIT : S_NEXT;
         S_NEXT:   state_nxt = last_elem ? S_FIN : S_FETCH;
         S_FIN:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath: dimension capture, counters, queue load/pop and the tx handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_r      <= 3'd0;
         n_r      <= 3'd0;
         row      <= 3'd0;
         col      <= 3'd0;
         addr     <= '0;
         q        <= '0;
         q_len    <= 3'd0;
         q_idx    <= 3'd0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         err      <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         err      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (dims_ok) begin
                     m_r  <= dim_m;
                     n_r  <= dim_n;
                     row  <= 3'd0;
                     col  <= 3'd0;
                     addr <= '0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_LATCH: begin
               q     <= q_nxt;
               q_len <= q_len_nxt;
               q_idx <= 3'd0;
            end
            S_EMIT: begin
               if (!tx_busy) begin
                  tx_start <= 1'b1;
                  tx_data  <= q[q_idx];
                  q_idx    <= q_idx + 3'd1;
               end
            end
            S_NEXT: begin
               if (!last_elem) begin
                  addr <= addr + ADDR_W'(1);
                  if (last_col) begin
                     col <= 3'd0;
                     row <= row + 3'd1;
                  end else begin
                     col <= col + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_tx_formatter.sv
// Bench for matrix_tx_formatter: storage and UART models, a text-level expected-byte
// model, and a negedge monitor comparing every byte, read and done against it.
module tb_matrix_tx_formatter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] dim_m = 3'd0, dim_n = 3'd0;
   logic       rd_en;
   logic [4:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic       tx_busy = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy, done, err;

   matrix_tx_formatter dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dim_m(dim_m), .dim_n(dim_n),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .tx_busy(tx_busy),
      .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Storage, expected model and monitor state.
   logic [7:0] mem [25];
   logic [7:0] exp_q [$];
   logic [7:0] lit_q [$];
   int         cum [26];
   int         frame_len = 0;
   int         sent = 0;
   int         sent_total = 0;
   int         exp_addr = 0;
   int         done_cnt = 0;
   logic [7:0] last_data = 8'h00;
   logic       prev_start = 1'b0;
   bit         stall = 1'b0;
   int         bcnt = 0;

   // Expected text: decimal digits, space between columns, CR LF after each row.
   task automatic build_model(input int m, input int n);
      int v;
      exp_q.delete();
      frame_len = 0;
      for (int r = 0; r < m; r++) begin
         for (int c = 0; c < n; c++) begin
            v = int'(mem[r*n + c]);
            cum[r*n + c] = exp_q.size();
            if (v >= 100) exp_q.push_back(8'(48 + v / 100));
            if (v >= 10)  exp_q.push_back(8'(48 + (v / 10) % 10));
            exp_q.push_back(8'(48 + v % 10));
            if (c < n - 1) exp_q.push_back(8'h20);
            else begin
               exp_q.push_back(8'h0D);
               exp_q.push_back(8'h0A);
            end
         end
      end
      frame_len = exp_q.size();
      sent = 0;
      exp_addr = 0;
   endtask

   task automatic check_model(input string name);
      check({name, "_len"}, exp_q.size(), lit_q.size());
      for (int i = 0; i < lit_q.size() && i < exp_q.size(); i++)
         check(name, {24'h0, exp_q[i]}, {24'h0, lit_q[i]});
   endtask

   // Storage: rd_data valid through the cycle after rd_en.
   always @(negedge clk) if (rd_en) rd_data = mem[rd_addr];

   // UART model: busy after each launched byte, optional long random stalls and
   // spontaneous busy periods so EMIT also sees tx_busy high.
   always @(negedge clk) begin
      if (tx_start) begin
         tx_busy = 1'b1;
         bcnt = stall ? int'($urandom_range(1, 500)) : 1;
      end else if (bcnt > 0) begin
         bcnt--;
         if (bcnt == 0) tx_busy = 1'b0;
      end else if (stall && $urandom_range(0, 15) == 0) begin
         tx_busy = 1'b1;
         bcnt = int'($urandom_range(1, 5));
      end
   end

   // Monitor: byte order, tx_data stability, pulse spacing, read ordering, done.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_data  = 8'h00;
         prev_start = 1'b0;
      end else begin
         if (tx_start) begin
            check("tx_start_gap", prev_start, 1'b0);
            if (exp_q.size() == 0) check("extra_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
            else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
            last_data = tx_data;
            sent++;
            sent_total++;
         end else begin
            check("tx_data_stable", {24'h0, tx_data}, {24'h0, last_data});
         end
         prev_start = tx_start;
         if (rd_en) begin
            check("rd_addr", {27'h0, rd_addr}, exp_addr);
            if (exp_addr < 25) check("rd_after_drain", sent, cum[exp_addr]);
            exp_addr++;
         end
         if (done) begin
            done_cnt++;
            check("done_byte_count", sent, frame_len);
            check("done_busy_low", busy, 1'b0);
         end
      end
   end

   task automatic pulse_start(input int m, input int n);
      @(negedge clk);
      start = 1'b1;
      dim_m = 3'(m);
      dim_n = 3'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int budget);
      int k = 0;
      while (done_cnt == d0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (done_cnt == d0) check("done_timeout", 0, 1);
   endtask

   task automatic finish_frame(input int d0);
      repeat (3) @(negedge clk);
      check("done_once", done_cnt - d0, 1);
      check("queue_drained", exp_q.size(), 0);
      check("busy_after", busy, 1'b0);
   endtask

   task automatic run_frame(input int m, input int n, input bit stall_on);
      int d0;
      stall = stall_on;
      build_model(m, n);
      d0 = done_cnt;
      pulse_start(m, n);
      check("busy_on_start", busy, 1'b1);
      wait_done(d0, 30000);
      finish_frame(d0);
      stall = 1'b0;
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_rd_en"}, rd_en, 1'b0);
      check({name, "_rd_addr"}, {27'h0, rd_addr}, 0);
      check({name, "_tx_start"}, tx_start, 1'b0);
      check({name, "_tx_data"}, {24'h0, tx_data}, 0);
      check({name, "_busy"}, busy, 1'b0);
      check({name, "_done"}, done, 1'b0);
      check({name, "_err"}, err, 1'b0);
   endtask

   initial begin
      int d0, k, s0;
      #1;
      check_idle_outputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 2x2 [1,20;255,0]
      mem[0] = 8'd1; mem[1] = 8'd20; mem[2] = 8'd255; mem[3] = 8'd0;
      build_model(2, 2);
      lit_q = '{8'h31, 8'h20, 8'h32, 8'h30, 8'h0D, 8'h0A,
                8'h32, 8'h35, 8'h35, 8'h20, 8'h30, 8'h0D, 8'h0A};
      check_model("model_2x2");
      run_frame(2, 2, 1'b0);

      // 1x1 [0]
      mem[0] = 8'd0;
      build_model(1, 1);
      lit_q = '{8'h30, 8'h0D, 8'h0A};
      check_model("model_1x1");
      run_frame(1, 1, 1'b0);

      // 1x5 all 9
      for (int i = 0; i < 5; i++) mem[i] = 8'd9;
      build_model(1, 5);
      lit_q = '{8'h39, 8'h20, 8'h39, 8'h20, 8'h39, 8'h20, 8'h39, 8'h20, 8'h39, 8'h0D, 8'h0A};
      check_model("model_1x5");
      run_frame(1, 5, 1'b0);

      // Illegal dimensions
      for (int t = 0; t < 3; t++) begin
         exp_q.delete();
         s0 = sent_total;
         @(negedge clk);
         start = 1'b1;
         dim_m = (t == 0) ? 3'd0 : (t == 1) ? 3'd2 : 3'd6;
         dim_n = (t == 0) ? 3'd3 : (t == 1) ? 3'd6 : 3'd1;
         @(negedge clk);
         start = 1'b0;
         check("err_pulse", err, 1'b1);
         check("err_busy", busy, 1'b0);
         @(negedge clk);
         check("err_single", err, 1'b0);
         repeat (20) @(negedge clk);
         check("err_no_tx", sent_total - s0, 0);
         check("err_busy_stays", busy, 1'b0);
      end

      // 2x2 again under long random UART stalls
      mem[0] = 8'd1; mem[1] = 8'd20; mem[2] = 8'd255; mem[3] = 8'd0;
      run_frame(2, 2, 1'b1);

      // 3x3 with start re-pulsed while busy
      for (int i = 0; i < 9; i++) mem[i] = 8'(i * 30);
      build_model(3, 3);
      d0 = done_cnt;
      pulse_start(3, 3);
      for (int r = 0; r < 3; r++) begin
         repeat (7) @(negedge clk);
         pulse_start(1, 1);
         check("restart_no_err", err, 1'b0);
      end
      wait_done(d0, 5000);
      repeat (50) @(negedge clk);
      finish_frame(d0);
      check("restart_bytes", sent, frame_len);

      // Reset in the middle of the third byte
      mem[0] = 8'd1; mem[1] = 8'd20; mem[2] = 8'd255; mem[3] = 8'd0;
      build_model(2, 2);
      pulse_start(2, 2);
      k = 0;
      while (sent < 3 && k < 2000) begin
         @(posedge clk);
         k++;
      end
      if (sent < 3) check("third_byte_timeout", 0, 1);
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("midreset");
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      repeat (10) @(negedge clk);
      check("midreset_no_done", done_cnt - d0, 0);
      check("midreset_idle", busy, 1'b0);

      mem[0] = 8'd7;
      build_model(1, 1);
      lit_q = '{8'h37, 8'h0D, 8'h0A};
      check_model("model_after_reset");
      run_frame(1, 1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
